mem_share_arbiter: RTL and testbench

//  Shares one single-port DEPTH x 32 register memory between two requesters:
//  the Wishbone slave port from the management SoC and an LA-driven port.

---
 rtl/mem_share_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_share_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_share_arbiter.sv
// mem_share_arbiter: round-robin share of one DEPTH x 32 register memory
// between the Wishbone slave port and an LA-driven port.
module mem_share_arbiter #(
  parameter int          AW        = 4,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  input  logic             la_req_i,
  input  logic             la_we_i,
  input  logic [AW-1:0]    la_addr_i,
  input  logic [31:0]      la_wdata_i,
  output logic             la_gnt_o,
  output logic             la_done_o,
  output logic [31:0]      la_rdata_o,
  output logic [CNT_W-1:0] conflict_cnt_o
);

  localparam int DEPTH = 2**AW;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic [31:0] mem [DEPTH];

  logic             wb_req;
  logic             both;
  logic             la_win;
  logic             accept;
  logic             last_la_q;
  logic             win_la_q;
  logic             we_q;
  logic             cyc_lost_q;
  logic [3:0]       sel_q;
  logic [AW-1:0]    addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rd_q;
  logic [31:0]      la_rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             unused_adr;

  assign unused_adr = ^wbs_adr_i[1:0];

  assign wb_req = wbs_cyc_i & wbs_stb_i &
                  (wbs_adr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign both   = wb_req & la_req_i;
  assign la_win = la_req_i & (~wb_req | ~last_la_q);
  assign accept = (state_q == IDLE) & (wb_req | la_req_i);

  assign wbs_dat_o      = wbs_ack_o ? rd_q : 32'h0;
  assign la_rdata_o     = la_rd_q;
  assign conflict_cnt_o = cnt_q;

  // next state and handshake pulses
  always_comb begin
    state_d   = state_q;
    la_gnt_o  = 1'b0;
    la_done_o = 1'b0;
    wbs_ack_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wb_req | la_req_i) begin
          state_d  = ACCESS;
          la_gnt_o = la_win & ~wb_rst_i;
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        state_d   = IDLE;
        la_done_o = win_la_q;
        wbs_ack_o = ~win_la_q & ~cyc_lost_q & wbs_cyc_i;
      end
      default: state_d = IDLE;
    endcase
  end

  // state, latched winner request, read data and contention count
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      last_la_q  <= 1'b1;
      win_la_q   <= 1'b0;
      we_q       <= 1'b0;
      cyc_lost_q <= 1'b0;
      sel_q      <= 4'h0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      rd_q       <= 32'h0;
      la_rd_q    <= 32'h0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        win_la_q   <= la_win;
        last_la_q  <= la_win;
        we_q       <= la_win ? la_we_i : wbs_we_i;
        sel_q      <= la_win ? 4'hF : wbs_sel_i;
        addr_q     <= la_win ? la_addr_i : wbs_adr_i[AW+1:2];
        wdata_q    <= la_win ? la_wdata_i : wbs_dat_i;
        cyc_lost_q <= 1'b0;
        if (both && cnt_q != '1)
          cnt_q <= cnt_q + CNT_W'(1);
      end
      if (state_q != IDLE && !wbs_cyc_i)
        cyc_lost_q <= 1'b1;
      if (state_q == ACCESS) begin
        rd_q <= mem[addr_q];
        if (win_la_q && !we_q)
          la_rd_q <= mem[addr_q];
      end
    end
  end

  // byte-masked write commits at the end of ACCESS
  always_ff @(posedge wb_clk_i) begin
    if (state_q == ACCESS && we_q) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_q[b])
          mem[addr_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_share_arbiter.sv
// tb_mem_share_arbiter: directed and random transactions checked
// against a transaction-level model of the shared memory.
module tb_mem_share_arbiter;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_i;
  logic        ack;
  logic [31:0] dat_o;
  logic        la_req, la_we;
  logic [3:0]  la_addr;
  logic [31:0] la_wdata;
  logic        la_gnt, la_done;
  logic [31:0] la_rdata;
  logic [15:0] cnt;
  logic        ack2, gnt2, done2;
  logic [31:0] dat_o2, rdata2;
  logic [1:0]  cnt2;

  logic [31:0] mem_m [16];
  bit          last_la;
  int          cnt_m;
  logic [31:0] la_rd_m;
  logic [31:0] last_wb_dat;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mem_share_arbiter dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_i),
    .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .la_req_i(la_req), .la_we_i(la_we), .la_addr_i(la_addr),
    .la_wdata_i(la_wdata), .la_gnt_o(la_gnt), .la_done_o(la_done),
    .la_rdata_o(la_rdata), .conflict_cnt_o(cnt)
  );

  mem_share_arbiter #(.CNT_W(2)) dut2 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_i),
    .wbs_ack_o(ack2), .wbs_dat_o(dat_o2),
    .la_req_i(la_req), .la_we_i(la_we), .la_addr_i(la_addr),
    .la_wdata_i(la_wdata), .la_gnt_o(gnt2), .la_done_o(done2),
    .la_rdata_o(rdata2), .conflict_cnt_o(cnt2)
  );

  task automatic idle_inputs();
    cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat_i = 0;
    la_req = 0; la_we = 0; la_addr = 0; la_wdata = 0;
  endtask

  task automatic check_cnt(input string nm);
    logic [1:0] e2;
    e2 = 2'((cnt_m > 3) ? 3 : cnt_m);
    checks++;
    if (cnt !== 16'(cnt_m)) begin
      errors++;
      $display("FAIL %s cnt got %0d want %0d", nm, cnt, cnt_m);
    end
    checks++;
    if (cnt2 !== e2) begin
      errors++;
      $display("FAIL %s cnt2 got %0d want %0d", nm, cnt2, e2);
    end
  endtask

  task automatic run_txn(
    input bit do_wb, input bit wwe, input logic [3:0] waddr,
    input logic [31:0] wdata, input logic [3:0] wsel,
    input bit do_la, input bit lwe, input logic [3:0] laddr,
    input logic [31:0] ldata
  );
    int t_wb, t_la;
    logic [31:0] exp_wrd, exp_lrd, la_old, exp_dat, exp_lr;
    bit e_ack, e_gnt, e_done;
    t_wb = -1; t_la = -1; exp_wrd = 0; exp_lrd = 0;
    if (do_wb && do_la) begin
      cnt_m++;
      if (last_la) begin t_wb = 0; t_la = 3; end
      else begin t_la = 0; t_wb = 3; end
    end else if (do_wb) t_wb = 0;
    else if (do_la) t_la = 0;
    if (do_wb || do_la) last_la = (t_la > t_wb);
    la_old = la_rd_m;
    for (int s = 0; s <= 3; s += 3) begin
      if (t_wb == s) begin
        if (wwe) begin
          for (int b = 0; b < 4; b++)
            if (wsel[b]) mem_m[waddr][8*b +: 8] = wdata[8*b +: 8];
        end else exp_wrd = mem_m[waddr];
      end
      if (t_la == s) begin
        if (lwe) mem_m[laddr] = ldata;
        else begin exp_lrd = mem_m[laddr]; la_rd_m = exp_lrd; end
      end
    end
    @(posedge clk); #1;
    cyc = do_wb; stb = do_wb; we = wwe; sel = wsel;
    adr = BASE | {26'd0, waddr, 2'b00}; dat_i = wdata;
    la_req = do_la; la_we = lwe; la_addr = laddr; la_wdata = ldata;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      e_ack  = (t_wb >= 0) && (k == t_wb + 2);
      e_gnt  = (t_la >= 0) && (k == t_la);
      e_done = (t_la >= 0) && (k == t_la + 2);
      exp_dat = (e_ack && !wwe) ? exp_wrd : 32'h0;
      exp_lr = (t_la >= 0 && !lwe && k >= t_la + 2) ? exp_lrd : la_old;
      checks++;
      if (ack !== e_ack) begin
        errors++;
        $display("FAIL ack k=%0d got %b want %b", k, ack, e_ack);
      end
      checks++;
      if (la_gnt !== e_gnt) begin
        errors++;
        $display("FAIL la_gnt k=%0d got %b want %b", k, la_gnt, e_gnt);
      end
      checks++;
      if (la_done !== e_done) begin
        errors++;
        $display("FAIL la_done k=%0d got %b want %b", k, la_done, e_done);
      end
      if (!(e_ack && wwe)) begin
        checks++;
        if (dat_o !== exp_dat) begin
          errors++;
          $display("FAIL wb_dat k=%0d got %h want %h", k, dat_o, exp_dat);
        end
      end
      checks++;
      if (la_rdata !== exp_lr) begin
        errors++;
        $display("FAIL la_rdata k=%0d got %h want %h", k, la_rdata, exp_lr);
      end
      if (ack) last_wb_dat = dat_o;
      @(posedge clk); #1;
      if (e_ack) begin cyc = 0; stb = 0; end
      if (e_done) la_req = 0;
    end
    check_cnt("txn");
  endtask

  task automatic wb_wr(input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    run_txn(1, 1, a, d, s, 0, 0, 0, 0);
  endtask

  task automatic wb_rd(input logic [3:0] a);
    run_txn(1, 0, a, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    cyc = 1; stb = 1; adr = BASE; la_req = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ack, la_gnt, la_done, ack2, gnt2, done2} !== 6'b0) begin
      errors++;
      $display("FAIL reset_hs got %b want 0",
               {ack, la_gnt, la_done, ack2, gnt2, done2});
    end
    checks++;
    if ({dat_o, la_rdata, cnt, cnt2} !== 82'b0) begin
      errors++;
      $display("FAIL reset_data got %h want 0", {dat_o, la_rdata, cnt, cnt2});
    end
    idle_inputs();
    @(posedge clk); #1;
    rst = 0;
    last_la = 1; cnt_m = 0; la_rd_m = 0;
  endtask

  task automatic test_tie();
    for (int i = 0; i < 4; i++)
      run_txn(1, 1, 4'($urandom), $urandom, 4'hF,
              1, 1, 4'($urandom), $urandom);
    checks++;
    if (cnt !== 16'd4) begin
      errors++;
      $display("FAIL tie_cnt got %0d want 4", cnt);
    end
    checks++;
    if (cnt2 !== 2'd3) begin
      errors++;
      $display("FAIL tie_sat got %0d want 3", cnt2);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++)
      wb_wr(4'(i), $urandom, 4'hF);
  endtask

  task automatic test_wb_basic();
    last_wb_dat = 0;
    wb_wr(3, 32'hDEADBEEF, 4'hF);
    wb_rd(3);
    checks++;
    if (last_wb_dat !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wb_rd1 got %h want deadbeef", last_wb_dat);
    end
    wb_wr(3, 32'h11223344, 4'b0101);
    wb_rd(3);
    checks++;
    if (last_wb_dat !== 32'hDE22BE44) begin
      errors++;
      $display("FAIL wb_sel got %h want de22be44", last_wb_dat);
    end
    wb_wr(3, 32'hFFFFFFFF, 4'h0);
    wb_rd(3);
    checks++;
    if (last_wb_dat !== 32'hDE22BE44) begin
      errors++;
      $display("FAIL wb_sel0 got %h want de22be44", last_wb_dat);
    end
  endtask

  task automatic test_la();
    run_txn(0, 0, 0, 0, 0, 1, 1, 15, 32'hA5A5A5A5);
    run_txn(0, 0, 0, 0, 0, 1, 0, 15, 0);
    checks++;
    if (la_rdata !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL la_rd got %h want a5a5a5a5", la_rdata);
    end
    wb_wr(15, 32'h0BADF00D, 4'hF);
    wb_rd(2);
    wb_rd(15);
    checks++;
    if (la_rdata !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL la_hold got %h want a5a5a5a5", la_rdata);
    end
  endtask

  task automatic test_window();
    logic [31:0] bad [2];
    bad[0] = 32'h4000_0018;
    bad[1] = BASE + 32'h40 + 32'h18;
    for (int j = 0; j < 2; j++) begin
      @(posedge clk); #1;
      cyc = 1; stb = 1; we = 1; sel = 4'hF;
      adr = bad[j]; dat_i = ~mem_m[6];
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        checks++;
        if (ack !== 1'b0) begin
          errors++;
          $display("FAIL window j=%0d k=%0d got %b want 0", j, k, ack);
        end
      end
      @(posedge clk); #1;
      idle_inputs();
    end
    wb_rd(6);
  endtask

  task automatic test_drop();
    logic [31:0] d;
    d = ~mem_m[5];
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 1; sel = 4'hF;
    adr = BASE | 32'h14; dat_i = d;
    @(negedge clk);
    @(posedge clk); #1;
    cyc = 0; stb = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (ack !== 1'b0) begin
        errors++;
        $display("FAIL cyc_drop k=%0d got %b want 0", k, ack);
      end
    end
    mem_m[5] = d; last_la = 0;
    wb_rd(5);
    d = ~mem_m[8];
    @(posedge clk); #1;
    la_req = 1; la_we = 1; la_addr = 8; la_wdata = d;
    @(negedge clk);
    checks++;
    if (la_gnt !== 1'b1) begin
      errors++;
      $display("FAIL la_drop_gnt got %b want 1", la_gnt);
    end
    @(posedge clk); #1;
    la_req = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (la_done !== (k == 2)) begin
        errors++;
        $display("FAIL la_drop_done k=%0d got %b want %b",
                 k, la_done, (k == 2));
      end
    end
    mem_m[8] = d; last_la = 1;
    run_txn(0, 0, 0, 0, 0, 1, 0, 8, 0);
  endtask

  task automatic check_zero_outs(input string nm);
    checks++;
    if ({ack, la_gnt, la_done, dat_o, la_rdata, cnt, cnt2} !== 85'b0) begin
      errors++;
      $display("FAIL %s got %h want 0", nm,
               {ack, la_gnt, la_done, dat_o, la_rdata, cnt, cnt2});
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    run_txn(0, 0, 0, 0, 0, 1, 0, 15, 0);
    d = ~mem_m[7];
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 1; sel = 4'hF;
    adr = BASE | 32'h1C; dat_i = d;
    @(posedge clk); #1;
    rst = 1; #1;
    check_zero_outs("rst_access");
    idle_inputs();
    @(posedge clk); #1;
    rst = 0;
    last_la = 1; cnt_m = 0; la_rd_m = 0;
    wb_rd(7);
    run_txn(0, 0, 0, 0, 0, 1, 0, 15, 0);
    d = ~mem_m[9];
    @(posedge clk); #1;
    la_req = 1; la_we = 1; la_addr = 9; la_wdata = d;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1; #1;
    check_zero_outs("rst_resp");
    idle_inputs();
    @(posedge clk); #1;
    rst = 0;
    last_la = 1; cnt_m = 0; la_rd_m = 0;
    mem_m[9] = d;
    run_txn(0, 0, 0, 0, 0, 1, 0, 9, 0);
    run_txn(1, 0, 9, 0, 0, 1, 0, 7, 0);
  endtask

  task automatic test_random();
    int kind;
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 2);
      run_txn(kind != 1, 1'($urandom), 4'($urandom), $urandom,
              4'($urandom), kind != 0, 1'($urandom), 4'($urandom),
              $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_tie();
    test_fill();
    test_wb_basic();
    test_la();
    test_window();
    test_drop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
